// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 16-bit CPU bus memory stage.
package cpu_bus_pkg;

    localparam int unsigned BUS_DATA_W = 16;
    localparam int unsigned BUS_ADDR_W = 16;

    localparam int unsigned IO_OUT_OFS = 0;
    localparam int unsigned IO_IN_OFS  = 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        HOLD
    } bus_state_t;

    typedef enum logic [1:0] {
        RgnRam,
        RgnIoOut,
        RgnIoIn,
        RgnNone
    } bus_rgn_t;

endpackage

// File: rtl/mem_sram_array.sv
// Single-port word RAM: synchronous write, registered read with enable, contents not reset.
module mem_sram_array #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus stage: wait-state FSM, address decode, internal RAM, memory-mapped
// I/O words and the tri-state driver for returning read data on the shared bus.
module mem_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int unsigned       DATA_W      = BUS_DATA_W,
    parameter int unsigned       ADDR_W      = BUS_ADDR_W,
    parameter int unsigned       DEPTH_LOG2  = 10,
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr_bus,
    input  logic              rd_mem,
    input  logic              wr_mem,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              mem_ready,
    output logic [DATA_W-1:0] io_out,
    input  logic [DATA_W-1:0] io_in,
    output logic              io_strobe,
    output logic              bus_err
);

    localparam logic [3:0]        WS_INIT    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [ADDR_W-1:0] IO_OUT_ADR = IO_BASE + ADDR_W'(IO_OUT_OFS);
    localparam logic [ADDR_W-1:0] IO_IN_ADR  = IO_BASE + ADDR_W'(IO_IN_OFS);

    bus_state_t        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr;
    bus_rgn_t          r_rgn;
    logic [DATA_W-1:0] r_rd_io;
    logic              r_mem_ready;
    logic              r_io_strobe;
    logic [DATA_W-1:0] r_io_out;
    logic              r_bus_err;

    logic              w_both;
    logic              w_one;
    logic              w_held;
    logic [ADDR_W-1:0] w_acc_adr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_acc_wr;
    logic              w_go_ack;
    bus_rgn_t          w_rgn;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_rdata;
    logic              w_drive;

    assign w_both = rd_mem & wr_mem;
    assign w_one  = rd_mem ^ wr_mem;
    assign w_held = rd_mem | wr_mem;

    // With zero wait states the access happens on the capture edge, so use the live bus.
    assign w_acc_adr   = (r_state == IDLE) ? adr_bus  : r_adr;
    assign w_acc_wdata = (r_state == IDLE) ? data_bus : r_wdata;
    assign w_acc_wr    = (r_state == IDLE) ? wr_mem   : r_wr;

    assign w_go_ack = ((r_state == IDLE) && w_one && (WAIT_STATES == 0)) ||
                      ((r_state == WAIT) && w_held && (r_cnt == 4'd0));

    always_comb begin
        w_rgn = RgnNone;
        if ((w_acc_adr >> DEPTH_LOG2) == '0) begin
            w_rgn = RgnRam;
        end else if (w_acc_adr == IO_OUT_ADR) begin
            w_rgn = RgnIoOut;
        end else if (w_acc_adr == IO_IN_ADR) begin
            w_rgn = RgnIoIn;
        end
    end

    assign w_ram_we = w_go_ack &  w_acc_wr & (w_rgn == RgnRam);
    assign w_ram_re = w_go_ack & ~w_acc_wr & (w_rgn == RgnRam);

    mem_sram_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_acc_adr[DEPTH_LOG2-1:0]),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            r_rgn       <= RgnNone;
            r_rd_io     <= '0;
            r_mem_ready <= 1'b0;
            r_io_strobe <= 1'b0;
            r_io_out    <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_mem_ready <= 1'b0;
            r_io_strobe <= 1'b0;
            if (w_both) begin
                r_bus_err <= 1'b1;
            end

            if (w_go_ack) begin
                r_mem_ready <= 1'b1;
                r_rgn       <= w_rgn;
                if (!w_acc_wr) begin
                    unique case (w_rgn)
                        RgnIoOut: r_rd_io <= r_io_out;
                        RgnIoIn:  r_rd_io <= io_in;
                        default:  r_rd_io <= '0;
                    endcase
                end else if (w_rgn == RgnIoOut) begin
                    r_io_out    <= w_acc_wdata;
                    r_io_strobe <= 1'b1;
                end
            end

            unique case (r_state)
                IDLE: begin
                    if (w_one) begin
                        r_adr   <= adr_bus;
                        r_wdata <= data_bus;
                        r_wr    <= wr_mem;
                        r_cnt   <= WS_INIT;
                        r_state <= (WAIT_STATES == 0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!w_held) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACK: begin
                    r_state <= w_held ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!w_held) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_rdata = (r_rgn == RgnRam) ? w_ram_q : r_rd_io;
    assign w_drive = ((r_state == ACK) || (r_state == HOLD)) && rd_mem && !wr_mem && !r_wr;

    assign data_bus  = w_drive ? w_rdata : 'z;
    assign mem_ready = r_mem_ready;
    assign io_out    = r_io_out;
    assign io_strobe = r_io_strobe;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomised bench for mem_bus_ctrl: two instances (1 and 3 wait states) against a
// transaction-level memory/IO model; a released bus reads back as all-ones via tri1.
module tb_mem_bus_ctrl;

    localparam logic [15:0] IO_BASE = 16'hFF00;
    localparam logic [15:0] REL     = 16'hFFFF;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] adr     [2];
    logic        rd      [2];
    logic        wr      [2];
    logic        drv     [2];
    logic [15:0] wdat    [2];
    logic [15:0] io_in_v [2];
    logic        mrdy    [2];
    logic        iost    [2];
    logic        berr    [2];
    logic [15:0] ioo     [2];

    tri1 [15:0] bus0;
    tri1 [15:0] bus1;
    assign bus0 = drv[0] ? wdat[0] : 16'hzzzz;
    assign bus1 = drv[1] ? wdat[1] : 16'hzzzz;

    logic [15:0] m_ram    [2][1024];
    logic [15:0] m_io_out [2];
    logic        m_berr   [2];
    logic [15:0] ram_pool [6];
    logic [15:0] unm_pool [5];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.WAIT_STATES(1)) u_dut0 (
        .clk(clk), .reset(reset_n), .adr_bus(adr[0]), .rd_mem(rd[0]), .wr_mem(wr[0]),
        .data_bus(bus0), .mem_ready(mrdy[0]), .io_out(ioo[0]), .io_in(io_in_v[0]),
        .io_strobe(iost[0]), .bus_err(berr[0])
    );

    mem_bus_ctrl #(.WAIT_STATES(3)) u_dut1 (
        .clk(clk), .reset(reset_n), .adr_bus(adr[1]), .rd_mem(rd[1]), .wr_mem(wr[1]),
        .data_bus(bus1), .mem_ready(mrdy[1]), .io_out(ioo[1]), .io_in(io_in_v[1]),
        .io_strobe(iost[1]), .bus_err(berr[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rnd16();
        logic [15:0] v;
        do v = 16'($urandom); while (v == REL);
        return v;
    endfunction

    function automatic logic [15:0] get_bus(input int k);
        return (k == 0) ? bus0 : bus1;
    endfunction

    function automatic logic [15:0] model_read(input int k, input logic [15:0] a);
        if (a < 16'h0400)        return m_ram[k][a[9:0]];
        if (a == IO_BASE)        return m_io_out[k];
        if (a == IO_BASE + 16'd1) return io_in_v[k];
        return 16'h0000;
    endfunction

    // Strobe raised just after edge N; completion expected after edge N+1+WAIT_STATES.
    task automatic do_xact(input int k, input bit is_wr, input logic [15:0] a,
                           input logic [15:0] d, input int hold);
        int          ws;
        logic [15:0] exp_rd;
        bit          exp_strb;
        ws = (k == 0) ? 1 : 3;
        @(posedge clk); #1;
        io_in_v[k] = rnd16();
        exp_rd     = model_read(k, a);
        exp_strb   = is_wr && (a == IO_BASE);
        adr[k] = a; wdat[k] = d; drv[k] = is_wr; rd[k] = !is_wr; wr[k] = is_wr;
        for (int c = 1; c <= ws; c++) begin
            @(posedge clk); #1;
            chk("ready_early", 32'(mrdy[k]), 32'd0);
            chk("strobe_early", 32'(iost[k]), 32'd0);
            if (!is_wr) chk("bus_rel_wait", 32'(get_bus(k)), 32'(REL));
            adr[k] = rnd16();
            if (is_wr) wdat[k] = rnd16();
        end
        if (is_wr) begin
            if (a < 16'h0400) m_ram[k][a[9:0]] = d;
            else if (a == IO_BASE) m_io_out[k] = d;
        end
        @(posedge clk); #1;
        chk("ready_ack", 32'(mrdy[k]), 32'd1);
        chk("io_strobe", 32'(iost[k]), 32'(exp_strb));
        chk("io_out", 32'(ioo[k]), 32'(m_io_out[k]));
        chk("bus_err", 32'(berr[k]), 32'(m_berr[k]));
        if (!is_wr) chk("rd_data_ack", 32'(get_bus(k)), 32'(exp_rd));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("ready_hold", 32'(mrdy[k]), 32'd0);
            chk("strobe_hold", 32'(iost[k]), 32'd0);
            if (!is_wr) chk("rd_data_hold", 32'(get_bus(k)), 32'(exp_rd));
        end
        rd[k] = 1'b0; wr[k] = 1'b0; drv[k] = 1'b0;
        #1;
        chk("bus_rel_drop", 32'(get_bus(k)), 32'(REL));
    endtask

    // Write on the 3-wait-state instance withdrawn while still waiting.
    task automatic do_abort(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        adr[1] = a; wdat[1] = d; drv[1] = 1'b1; wr[1] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            chk("abort_ready", 32'(mrdy[1]), 32'd0);
            chk("abort_strobe", 32'(iost[1]), 32'd0);
            chk("abort_io_out", 32'(ioo[1]), 32'(m_io_out[1]));
            if (c == 2) begin
                wr[1] = 1'b0; drv[1] = 1'b0;
            end
        end
    endtask

    int          k_r;
    int          sel_r;
    bit          wr_r;
    logic [15:0] a_r;

    initial begin
        ram_pool = '{16'h0000, 16'h0010, 16'h0123, 16'h02AA, 16'h03FE, 16'h03FF};
        unm_pool = '{16'h0400, 16'h8000, 16'hFEFF, 16'hFF02, 16'hFFFF};
        for (int k = 0; k < 2; k++) begin
            adr[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0; drv[k] = 1'b0;
            wdat[k] = '0; io_in_v[k] = '0; m_io_out[k] = '0; m_berr[k] = 1'b0;
        end
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(mrdy[k]), 32'd0);
            chk("rst_strobe", 32'(iost[k]), 32'd0);
            chk("rst_io_out", 32'(ioo[k]), 32'd0);
            chk("rst_bus_err", 32'(berr[k]), 32'd0);
            chk("rst_bus_rel", 32'(get_bus(k)), 32'(REL));
        end
        reset_n = 1'b1;

        // Directed: RAM round trip, IO words, unmapped space, boundary addresses.
        do_xact(0, 1'b1, 16'h0010, 16'hBEEF, 0);
        do_xact(0, 1'b0, 16'h0010, 16'h0000, 1);
        do_xact(0, 1'b1, IO_BASE, 16'h00A5, 0);
        do_xact(0, 1'b0, IO_BASE + 16'd1, 16'h0000, 0);
        do_xact(0, 1'b0, IO_BASE, 16'h0000, 2);
        do_xact(0, 1'b1, IO_BASE + 16'd1, 16'h7777, 0);
        do_xact(0, 1'b0, 16'h8000, 16'h0000, 0);
        do_xact(0, 1'b1, 16'h8000, 16'h5A5A, 0);
        do_xact(0, 1'b1, 16'h0400, 16'h6B6B, 0);
        do_xact(0, 1'b0, 16'h0010, 16'h0000, 0);
        do_xact(0, 1'b0, IO_BASE, 16'h0000, 0);

        do_xact(1, 1'b1, 16'h0020, 16'h1111, 0);
        do_abort(16'h0020, 16'h2222);
        do_xact(1, 1'b0, 16'h0020, 16'h0000, 1);

        // Conflicting strobes in IDLE: error latched, no access.
        @(posedge clk); #1;
        rd[0] = 1'b1; wr[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            chk("both_ready", 32'(mrdy[0]), 32'd0);
            chk("both_bus_rel", 32'(get_bus(0)), 32'(REL));
            chk("both_bus_err", 32'(berr[0]), 32'd1);
        end
        rd[0] = 1'b0; wr[0] = 1'b0;
        m_berr[0] = 1'b1;

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) do_xact(k, 1'b1, ram_pool[i], rnd16(), 0);
        end

        for (int i = 0; i < 240; i++) begin
            k_r   = $urandom_range(0, 1);
            sel_r = $urandom_range(0, 9);
            wr_r  = 1'($urandom_range(0, 1));
            if (sel_r < 6)       a_r = ram_pool[$urandom_range(0, 5)];
            else if (sel_r == 6) a_r = IO_BASE;
            else if (sel_r == 7) a_r = IO_BASE + 16'd1;
            else                 a_r = unm_pool[$urandom_range(0, 4)];
            if (k_r == 1 && $urandom_range(0, 9) == 0) do_abort(a_r, rnd16());
            else do_xact(k_r, wr_r, a_r, rnd16(), $urandom_range(0, 2));
        end

        // Reset while instance 0 is acknowledging a read and instance 1 is still waiting.
        @(posedge clk); #1;
        io_in_v[0] = rnd16(); io_in_v[1] = rnd16();
        adr[0] = 16'h0010; adr[1] = 16'h0020; rd[0] = 1'b1; rd[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pre_ready", 32'(mrdy[0]), 32'd1);
        chk("rst_pre_data", 32'(bus0), 32'(m_ram[0][16]));
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_mid_ready", 32'(mrdy[k]), 32'd0);
            chk("rst_mid_bus_rel", 32'(get_bus(k)), 32'(REL));
            chk("rst_mid_io_out", 32'(ioo[k]), 32'd0);
            chk("rst_mid_bus_err", 32'(berr[k]), 32'd0);
            m_io_out[k] = '0; m_berr[k] = 1'b0;
        end
        rd[0] = 1'b0; rd[1] = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        do_xact(1, 1'b0, 16'h0020, 16'h0000, 0);
        do_xact(0, 1'b0, 16'h0010, 16'h0000, 1);
        do_xact(1, 1'b0, IO_BASE, 16'h0000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
